dcpu_bus_arbiter: RTL
=====================

Name: dcpu_bus_arbiter

Overview:
Two-master, one-slave arbiter for the dcpu memory bus (addr/dat/we/cs/ack handshake). Master 0 is the dcpu core; master 1 is a secondary requester such as a debug loader or DMA. The block sits between both masters and the single memory/IO bus. It grants round-robin, routes ack/data back only to the granted master, and aborts hung transfers with a timeout.

Parameters:
TIMEOUT, 64, cycles of asserted o_cs without i_ack before a forced error completion; 0 disables the timeout; legal range 0..255.

Ports:
i_clk  in  1  clock; all state updates on its rising edge
i_reset  in  1  reset, asynchronous, active-high
i_m0_addr  in  16  master 0 address
i_m0_dat  in  16  master 0 write data
i_m0_we  in  1  master 0 write enable
i_m0_cs  in  1  master 0 request, held until its ack
o_m0_dat  out  16  read data to master 0
o_m0_ack  out  1  master 0 transfer complete (1-cycle pulse)
o_m0_err  out  1  master 0 transfer timed out (pulses together with o_m0_ack)
i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs, o_m1_dat, o_m1_ack, o_m1_err  same as master 0, for master 1
o_addr  out  16  slave address
o_dat  out  16  slave write data
o_we  out  1  slave write enable
o_cs  out  1  slave chip select
i_dat  in  16  slave read data
i_ack  in  1  slave ack
o_gnt  out  2  one-hot current grant; bit0 = master 0, bit1 = master 1

Behaviour:
- Clock is i_clk. Reset is i_reset, asynchronous, active-high.
- Reset values: state IDLE, o_gnt=0, r_last=1 (master 0 wins the first tie), timeout counter 0.
- Reset also drives all outputs 0. This holds when reset is asserted mid-transfer: the transfer is dropped and no ack or err is issued.
- States: IDLE, GNT0, GNT1. o_gnt = {state==GNT1, state==GNT0}.
- IDLE, next-state rules:
  - only m0 cs asserted -> GNT0
  - only m1 cs asserted -> GNT1
  - both asserted -> grant the master != r_last
  - neither asserted -> stay IDLE
  - r_last is updated to the granted master on entry to GNT0/GNT1.
- Grant latency: one cycle. A request seen at edge N is granted and drives o_cs from cycle N+1.
- While in GNTx:
  - o_addr = i_mx_addr, o_dat = i_mx_dat, o_we = i_mx_we & i_mx_cs, o_cs = i_mx_cs (all combinational).
- In IDLE: o_addr, o_dat, o_we and o_cs are all 0.
- o_m0_dat and o_m1_dat both equal i_dat (combinational). The value is only meaningful during that master's ack.
- o_mx_ack = (state==GNTx) & (i_ack | timeout_hit). The non-granted master never sees ack. i_ack in IDLE is ignored.
- Completion: on an edge where o_mx_ack=1, state returns to IDLE. There is always one IDLE cycle between transfers, so back-to-back requests from m0 interleave fairly with m1.
- Abort: if the granted master drops cs before ack, state returns to IDLE at the next edge, with no ack and no err.
- Timeout counter (8-bit):
  - cleared in IDLE;
  - increments each GNTx cycle with o_cs=1 and i_ack=0;
  - timeout_hit = (TIMEOUT!=0) & (counter==TIMEOUT-1) & o_cs & ~i_ack.
- On timeout_hit: o_mx_ack=1 and o_mx_err=1 for exactly one cycle, then IDLE.
- i_ack coinciding with the timeout cycle: the ack wins and err=0.
- With TIMEOUT=0, o_mx_err is never asserted.

Test Plan:
- Reset, then m0 cs=1 with addr=0x0010, slave acks 2 cycles after o_cs with i_dat=0xBEEF -> o_cs rises one cycle after request; o_m0_ack=1 with o_m0_dat=0xBEEF; o_m1_ack stays 0; IDLE the following cycle.
- m0 and m1 both assert cs continuously, slave acks in 1 cycle -> grants alternate GNT0, GNT1, GNT0, …, starting with m0 after reset, with one IDLE cycle between each.
- m1 write addr=0x8000 dat=0x1234 we=1 -> o_we=1, o_addr=0x8000, o_dat=0x1234 while granted; o_we=0 in IDLE.
- TIMEOUT=4, slave never acks -> o_m0_ack and o_m0_err pulse together in the 4th o_cs cycle, then IDLE; with i_ack in that same cycle, err=0.
- m1 granted, i_reset pulsed asynchronously mid-transfer -> o_cs and o_gnt drop to 0 immediately; no ack; m0 is granted first afterwards.

Source files
------------

// File: rtl/dcpu_bus_arbiter.sv
// Two-master round-robin arbiter for the dcpu memory bus.
// Routes ack/data to the granted master and aborts hung transfers on timeout.
module dcpu_bus_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_m0_addr,
    input  logic [15:0] i_m0_dat,
    input  logic        i_m0_we,
    input  logic        i_m0_cs,
    output logic [15:0] o_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic [15:0] i_m1_addr,
    input  logic [15:0] i_m1_dat,
    input  logic        i_m1_we,
    input  logic        i_m1_cs,
    output logic [15:0] o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [15:0] o_addr,
    output logic [15:0] o_dat,
    output logic        o_we,
    output logic        o_cs,
    input  logic [15:0] i_dat,
    input  logic        i_ack,
    output logic [1:0]  o_gnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    localparam bit         LP_TO_EN = (TIMEOUT != 0);
    localparam logic [7:0] LP_TMAX  = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [1:0] r_gnt;
    logic       r_last;
    logic [7:0] r_cnt;

    logic w_in0;
    logic w_in1;
    logic w_pick0;
    logic w_pick1;
    logic w_hit;
    logic w_done;
    logic w_cs_g;

    assign w_in0 = (r_state == S_GNT0);
    assign w_in1 = (r_state == S_GNT1);

    // r_last names the previous winner; on a tie the other master goes
    assign w_pick0 = i_m0_cs & (~i_m1_cs | r_last);
    assign w_pick1 = i_m1_cs & (~i_m0_cs | ~r_last);

    assign w_cs_g = (w_in0 & i_m0_cs) | (w_in1 & i_m1_cs);
    assign w_hit  = LP_TO_EN & (r_cnt == LP_TMAX) & w_cs_g & ~i_ack;
    assign w_done = i_ack | w_hit;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_pick0) begin
                        r_state <= S_GNT0;
                        r_gnt   <= 2'b01;
                        r_last  <= 1'b0;
                    end else if (w_pick1) begin
                        r_state <= S_GNT1;
                        r_gnt   <= 2'b10;
                        r_last  <= 1'b1;
                    end
                end
                S_GNT0, S_GNT1: begin
                    if (w_done | ~w_cs_g) begin
                        r_state <= S_IDLE;
                        r_gnt   <= 2'b00;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 2'b00;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        o_addr = 16'd0;
        o_dat  = 16'd0;
        o_we   = 1'b0;
        o_cs   = 1'b0;
        if (w_in0) begin
            o_addr = i_m0_addr;
            o_dat  = i_m0_dat;
            o_we   = i_m0_we & i_m0_cs;
            o_cs   = i_m0_cs;
        end else if (w_in1) begin
            o_addr = i_m1_addr;
            o_dat  = i_m1_dat;
            o_we   = i_m1_we & i_m1_cs;
            o_cs   = i_m1_cs;
        end
    end

    // ack beats a coincident timeout, so err only flags a true expiry
    assign o_m0_ack = w_in0 & w_done;
    assign o_m1_ack = w_in1 & w_done;
    assign o_m0_err = w_in0 & w_hit;
    assign o_m1_err = w_in1 & w_hit;

    assign o_m0_dat = i_reset ? 16'd0 : i_dat;
    assign o_m1_dat = i_reset ? 16'd0 : i_dat;
    assign o_gnt    = r_gnt;

endmodule
